// File: rtl/mux_arb_n.sv
// N-channel valid/ready multiplexer with round-robin or fixed-priority arbitration and a registered output stage.
// Optional burst locking is enabled by defining MUX_ARB_LOCK_EN (adds the in_last port).
module mux_arb_n #(
  parameter  int WIDTH = 32,
  parameter  int NCH   = 8,
  parameter  int RR    = 1,
  localparam int CHW   = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
`ifdef MUX_ARB_LOCK_EN
  input  logic [NCH-1:0]       in_last,
`endif
  output logic [WIDTH-1:0]     out,
  output logic [CHW-1:0]       out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic             load_s;
  logic             gnt_valid_s;
  logic [CHW-1:0]   gnt_idx_s;
  logic [CHW-1:0]   base_s;
  logic [CHW-1:0]   next_s;
  logic [CHW:0]     cand_s;
  logic [NCH-1:0]   elig_s;
  logic [WIDTH-1:0] gnt_data_s;
  logic [CHW-1:0]   ptr_r;
`ifdef MUX_ARB_LOCK_EN
  logic             lock_r;
  logic [CHW-1:0]   lock_ch_r;
`endif

  assign load_s = !out_valid || out_ready;

  // Channels allowed to compete this cycle (restricted to the locked channel mid-burst).
  always_comb begin
`ifdef MUX_ARB_LOCK_EN
    if (lock_r) begin
      elig_s = in_valid & ({{(NCH-1){1'b0}}, 1'b1} << lock_ch_r);
    end else begin
      elig_s = in_valid;
    end
`else
    elig_s = in_valid;
`endif
  end

  // Priority search starting at the pointer (or channel 0 for fixed priority), ascending with wrap.
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_idx_s   = '0;
    cand_s      = '0;
    if (RR != 0) begin
      base_s = ptr_r;
    end else begin
      base_s = '0;
    end
    for (int i = 0; i < NCH; i++) begin
      cand_s = {1'b0, base_s} + (CHW+1)'(i);
      if (cand_s >= (CHW+1)'(NCH)) begin
        cand_s = cand_s - (CHW+1)'(NCH);
      end else begin
        cand_s = cand_s;
      end
      if (!gnt_valid_s && elig_s[cand_s[CHW-1:0]]) begin
        gnt_valid_s = 1'b1;
        gnt_idx_s   = cand_s[CHW-1:0];
      end else begin
        gnt_valid_s = gnt_valid_s;
      end
    end
  end

  // Granted word select and next pointer value.
  always_comb begin
    gnt_data_s = '0;
    for (int k = 0; k < NCH; k++) begin
      if (gnt_idx_s == CHW'(k)) begin
        gnt_data_s = in_data[k*WIDTH +: WIDTH];
      end else begin
        gnt_data_s = gnt_data_s;
      end
    end
    if (gnt_idx_s == CHW'(NCH-1)) begin
      next_s = '0;
    end else begin
      next_s = gnt_idx_s + CHW'(1);
    end
  end

  // One-hot accept, forced low while in reset or while the output is stalled.
  always_comb begin
    in_ready = '0;
    if (rst_n && load_s && gnt_valid_s) begin
      in_ready[gnt_idx_s] = 1'b1;
    end else begin
      in_ready = '0;
    end
  end

  // Output register, priority pointer and burst lock state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      ptr_r     <= '0;
`ifdef MUX_ARB_LOCK_EN
      lock_r    <= 1'b0;
      lock_ch_r <= '0;
`endif
    end else if (load_s) begin
      if (gnt_valid_s) begin
        out       <= gnt_data_s;
        out_ch    <= gnt_idx_s;
        out_valid <= 1'b1;
`ifdef MUX_ARB_LOCK_EN
        if (in_last[gnt_idx_s]) begin
          lock_r <= 1'b0;
          if (RR != 0) begin
            ptr_r <= next_s;
          end
        end else begin
          lock_r    <= 1'b1;
          lock_ch_r <= gnt_idx_s;
        end
`else
        if (RR != 0) begin
          ptr_r <= next_s;
        end
`endif
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed scoreboard bench for mux_arb_n: a round-robin and a fixed-priority instance.
// Burst-lock vectors run only when MUX_ARB_LOCK_EN is defined.
`timescale 1ns/1ps
module tb_mux_arb_n;

  localparam int W = 32;
  localparam int N = 8;

  typedef struct packed {
    logic [2:0]  ch;
    logic [31:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0] in_valid, in_valid0, in_last;
  logic [N-1:0] in_ready, in_ready0;
  logic [W-1:0] out, out0;
  logic [2:0]   out_ch, out_ch0;
  logic         out_valid, out_valid0;
  logic         out_ready, out_ready0;

  int n_total = 0;
  int n_pass  = 0;
  exp_t q1[$];
  exp_t q0[$];
  exp_t e1, e0;

  always #5 clk = ~clk;

  mux_arb_n #(.WIDTH(W), .NCH(N), .RR(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
`ifdef MUX_ARB_LOCK_EN
    .in_last(in_last),
`endif
    .out(out), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_arb_n #(.WIDTH(W), .NCH(N), .RR(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid0), .in_ready(in_ready0),
`ifdef MUX_ARB_LOCK_EN
    .in_last(in_last),
`endif
    .out(out0), .out_ch(out_ch0), .out_valid(out_valid0), .out_ready(out_ready0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push1(input int ch, input logic [31:0] d);
    exp_t e;
    e.ch = 3'(ch);
    e.data = d;
    q1.push_back(e);
  endtask

  task automatic push0(input int ch, input logic [31:0] d);
    exp_t e;
    e.ch = 3'(ch);
    e.data = d;
    q0.push_back(e);
  endtask

  // Round-robin instance monitor: each word accepted downstream must match the next expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q1.size() == 0) begin
        n_total++;
        $display("FAIL rr1_unexpected: got ch %0d data %h, expected no word at %0t", out_ch, out, $time);
      end else begin
        e1 = q1.pop_front();
        check("rr1_ch", 32'(out_ch), 32'(e1.ch));
        check("rr1_data", out, e1.data);
      end
    end
  end

  // Fixed-priority instance monitor.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid0 === 1'b1 && out_ready0 === 1'b1) begin
      if (q0.size() == 0) begin
        n_total++;
        $display("FAIL fp_unexpected: got ch %0d data %h, expected no word at %0t", out_ch0, out0, $time);
      end else begin
        e0 = q0.pop_front();
        check("fp_ch", 32'(out_ch0), 32'(e0.ch));
        check("fp_data", out0, e0.data);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    in_valid = '0;
    in_valid0 = '0;
    in_last = '1;
    out_ready = 1'b1;
    out_ready0 = 1'b1;
    for (int k = 0; k < N; k++) in_data[k*W +: W] = 32'hA0 + 32'(k);

    // Reset state
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", out, 32'd0);
    check("rst_out_ch", 32'(out_ch), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_fp_out_valid", 32'(out_valid0), 32'd0);
    #9 rst_n = 1'b1;

    // Idle: nothing valid
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_out_valid", 32'(out_valid), 32'd0);
      check("idle_out_ch", 32'(out_ch), 32'd0);
      check("idle_in_ready", 32'(in_ready), 32'd0);
    end

    // Round-robin sweep with all channels requesting, one word per cycle
    for (int i = 0; i < 9; i++) push1(i % N, 32'hA0 + 32'(i % N));
    @(posedge clk); #1;
    in_valid = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      if (i == 8) in_valid = '0;
      @(negedge clk);
      check("rr_throughput_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk); #1;
    check("rr_drain_valid", 32'(out_valid), 32'd0);

    // Stall: DEADBEEF held while out_ready is low (pointer is at 1, channel 5 wins)
    in_data[5*W +: W] = 32'hDEADBEEF;
    in_valid = 8'h20;
    out_ready = 1'b0;
    push1(5, 32'hDEADBEEF);
    push1(6, 32'hA6);
    @(posedge clk); #1;
    in_valid = 8'h40;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_out", out, 32'hDEADBEEF);
      check("stall_out_ch", 32'(out_ch), 32'd5);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("unstall_in_ready", 32'(in_ready), 32'h40);
    @(posedge clk); #1;
    in_valid = '0;
    in_data[5*W +: W] = 32'hA5;

    // Async reset mid-stall (pointer is at 7, channel 3 wins), word discarded
    @(posedge clk); #1;
    in_valid = 8'h08;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = '0;
    @(negedge clk);
    check("prerst_out_valid", 32'(out_valid), 32'd1);
    check("prerst_out_ch", 32'(out_ch), 32'd3);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_out", out, 32'd0);
    check("async_rst_out_ch", 32'(out_ch), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd0);
    #1;
    rst_n = 1'b1;
    in_valid = 8'hFF;
    out_ready = 1'b1;
    push1(0, 32'hA0);
    push1(1, 32'hA1);
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'h01);
    @(posedge clk);
    @(posedge clk); #1;
    in_valid = '0;

`ifdef MUX_ARB_LOCK_EN
    // Burst lock on channel 3 (pointer is at 2)
    push1(3, 32'hA3);
    push1(3, 32'hA3);
    push1(3, 32'hA3);
    push1(4, 32'hA4);
    @(posedge clk); #1;
    in_valid = 8'h08;
    in_last = 8'hF7;
    @(posedge clk); #1;
    in_valid = 8'hFF;
    @(negedge clk);
    check("lock_in_ready", 32'(in_ready), 32'h08);
    @(posedge clk); #1;
    in_last = 8'hFF;
    @(posedge clk); #1;
    @(negedge clk);
    check("unlock_in_ready", 32'(in_ready), 32'h10);
    @(posedge clk); #1;
    in_valid = '0;
`endif

    // Fixed priority: channel 2 beats 5 every cycle, then 4 beats 5
    for (int i = 0; i < 6; i++) push0(2, 32'hA2);
    push0(4, 32'hA4);
    push0(4, 32'hA4);
    @(posedge clk); #1;
    in_valid0 = 8'h24;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("fp_in_ready_24", 32'(in_ready0), 32'h04);
      @(posedge clk); #1;
    end
    in_valid0 = 8'h30;
    @(negedge clk);
    check("fp_in_ready_30", 32'(in_ready0), 32'h10);
    @(posedge clk);
    @(posedge clk); #1;
    in_valid0 = '0;

    repeat (3) @(negedge clk);
    check("rr1_queue_drained", 32'(q1.size()), 32'd0);
    check("fp_queue_drained", 32'(q0.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
